// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit controller.
package uart_pkg;

  // Transmit sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    GAP  = 2'd3
  } tx_ctrl_state_t;

  // Baud ticks per frame as seen by uart_tx: idle, start, 8 data, stop, done.
  localparam int unsigned UART_FRAME_TICKS = 12;

  localparam int unsigned UART_DATA_W = 8;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO; head word is visible combinationally on dout.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [LW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  // A push while full is still taken when a pop frees the slot in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign full  = (count == LW'(DEPTH));
  assign empty = (count == '0);
  assign level = count;
  assign dout  = mem[rd_ptr];

  // Storage array; no reset needed, contents are qualified by count.
  always_ff @(posedge i_clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= AW'(wr_ptr + 1'b1);
      end
      if (do_pop) begin
        rd_ptr <= AW'(rd_ptr + 1'b1);
      end
      count <= LW'(count + LW'(do_push) - LW'(do_pop));
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: byte FIFO, baud enable and frame sequencing for uart_tx.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DIV_W      = 16
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_enable,
  input  logic [DIV_W-1:0]              i_baud_div,
  input  logic                          i_wr,
  input  logic [7:0]                    i_wdata,
  input  logic                          i_clr_ovf,
  output logic                          o_full,
  output logic                          o_empty,
  output logic [$clog2(FIFO_DEPTH):0]   o_level,
  output logic                          o_overflow,
  output logic                          o_busy,
  output logic                          o_txclken,
  output logic                          o_txrun,
  output logic [7:0]                    o_txdata,
  input  logic                          i_txdone
);

  tx_ctrl_state_t   state;
  tx_ctrl_state_t   state_nxt;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] cnt_nxt;
  logic             txrun_nxt;
  logic             txclken_nxt;
  logic [7:0]       txdata_nxt;
  logic             ovf_nxt;
  logic             pop;
  logic [7:0]       fifo_dout;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_W)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .push    (i_wr),
    .pop     (pop),
    .din     (i_wdata),
    .dout    (fifo_dout),
    .level   (o_level),
    .full    (o_full),
    .empty   (o_empty)
  );

  // Next-state, baud counter and output decode; the tick is computed from next
  // values so the registered o_txclken lines up with cnt==i_baud_div in RUN.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = '0;
    txrun_nxt  = o_txrun;
    txdata_nxt = o_txdata;
    pop        = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_enable && !o_empty) begin
          pop        = 1'b1;
          txdata_nxt = fifo_dout;
          state_nxt  = LOAD;
        end
      end
      LOAD: begin
        state_nxt = RUN;
        txrun_nxt = 1'b1;
      end
      RUN: begin
        if (i_txdone) begin
          state_nxt = GAP;
          txrun_nxt = 1'b0;
        end else if (cnt != i_baud_div) begin
          cnt_nxt = DIV_W'(cnt + 1'b1);
        end
      end
      GAP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        txrun_nxt = 1'b0;
      end
    endcase
    txclken_nxt = (state_nxt == RUN) && (cnt_nxt == i_baud_div);
    // A new overflow beats a simultaneous clear.
    if (i_wr && o_full && !pop) begin
      ovf_nxt = 1'b1;
    end else if (i_clr_ovf) begin
      ovf_nxt = 1'b0;
    end else begin
      ovf_nxt = o_overflow;
    end
  end

  // State and registered outputs; reset drops o_txrun immediately.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state      <= IDLE;
      cnt        <= '0;
      o_txrun    <= 1'b0;
      o_txclken  <= 1'b0;
      o_txdata   <= 8'h00;
      o_overflow <= 1'b0;
      o_busy     <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      o_txrun    <= txrun_nxt;
      o_txclken  <= txclken_nxt;
      o_txdata   <= txdata_nxt;
      o_overflow <= ovf_nxt;
      o_busy     <= (state_nxt != IDLE);
    end
  end

endmodule
